// File: rtl/ssb_re_demapper.sv
// SSB resource-element demapper: ping-pong buffers one FFT symbol, reads it back
// in SSB subcarrier order and routes REs to the SSS and PBCH streams with DMRS flags.
module ssb_re_demapper #(
  parameter int DW = 42
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic [DW-1:0] s_axis_in_tdata,
  input  logic          s_axis_in_tvalid,
  input  logic          symbol_start_i,
  input  logic          PBCH_valid_i,
  input  logic          SSS_valid_i,
  input  logic [9:0]    N_id_i,
  output logic [DW-1:0] m_axis_sss_tdata,
  output logic          m_axis_sss_tvalid,
  output logic          m_axis_sss_tlast,
  output logic [DW-1:0] m_axis_pbch_tdata,
  output logic          m_axis_pbch_tvalid,
  output logic          m_axis_pbch_tuser,
  output logic          m_axis_pbch_tlast,
  output logic          err_abort_o,
  output logic          err_overrun_o
);

  localparam int FFT_LEN   = 256;
  localparam int SSB_SC    = 240;
  localparam int SSS_START = 56;

  localparam logic [7:0] BIN_LAST      = 8'(FFT_LEN - 1);
  localparam logic [7:0] K_LAST        = 8'(SSB_SC - 1);
  // SSB centre sits on DC, so k=0 maps to the negative-frequency edge bin
  localparam logic [7:0] BIN_OFFSET    = 8'(FFT_LEN - SSB_SC / 2);
  localparam logic [7:0] SSS_FIRST     = 8'(SSS_START);
  localparam logic [7:0] SSS_LAST      = 8'(SSS_START + 126);
  localparam logic [7:0] PBCH_LO_LAST  = 8'd47;
  localparam logic [7:0] PBCH_HI_FIRST = 8'd192;

  typedef enum logic [1:0] {KIND_NONE = 2'd0, KIND_PBCH = 2'd1, KIND_SSS = 2'd2} kind_e;
  typedef enum logic {WR_IDLE = 1'b0, WR_FILL = 1'b1} wr_state_e;
  typedef enum logic {RD_IDLE = 1'b0, RD_READ = 1'b1} rd_state_e;

  logic [DW-1:0] mem_r [2*FFT_LEN];

  wr_state_e     wr_state_r, wr_state_nxt_s;
  logic [7:0]    wr_cnt_r;
  logic          wr_bank_r;
  kind_e         wr_kind_r;
  logic [1:0]    wr_v_r;
  logic          wr_en_s, start_s, done_s;
  logic [7:0]    wr_bin_s;

  rd_state_e     rd_state_r, rd_state_nxt_s;
  logic [7:0]    rd_k_r;
  logic          rd_bank_r;
  kind_e         rd_kind_r;
  logic [1:0]    rd_v_r;
  logic          rd_go_s;
  logic [7:0]    rd_addr_s;
  logic          sss_sel_s, sss_last_s, pbch_sel_s, pbch_last_s, dmrs_s;

  assign rd_addr_s = rd_k_r + BIN_OFFSET;
  assign dmrs_s    = (rd_k_r[1:0] == rd_v_r);

  // Write FSM next state; a symbol start always restarts at bin 0
  always_comb begin
    wr_state_nxt_s = wr_state_r;
    wr_en_s        = 1'b0;
    wr_bin_s       = wr_cnt_r;
    start_s        = 1'b0;
    done_s         = 1'b0;
    if (s_axis_in_tvalid && symbol_start_i) begin
      start_s        = 1'b1;
      wr_en_s        = 1'b1;
      wr_bin_s       = 8'd0;
      wr_state_nxt_s = WR_FILL;
    end else begin
      case (wr_state_r)
        WR_FILL: begin
          wr_en_s = s_axis_in_tvalid;
          if (s_axis_in_tvalid && (wr_cnt_r == BIN_LAST)) begin
            done_s         = 1'b1;
            wr_state_nxt_s = WR_IDLE;
          end else begin
            wr_state_nxt_s = WR_FILL;
          end
        end
        WR_IDLE: wr_state_nxt_s = WR_IDLE;
        default: wr_state_nxt_s = WR_IDLE;
      endcase
    end
  end

  // Write FSM state, bin counter, bank pointer and per-symbol capture
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_state_r  <= WR_IDLE;
      wr_cnt_r    <= 8'd0;
      wr_bank_r   <= 1'b0;
      wr_kind_r   <= KIND_NONE;
      wr_v_r      <= 2'd0;
      err_abort_o <= 1'b0;
    end else begin
      wr_state_r <= wr_state_nxt_s;
      if (start_s) begin
        wr_cnt_r  <= 8'd1;
        wr_kind_r <= SSS_valid_i ? KIND_SSS : (PBCH_valid_i ? KIND_PBCH : KIND_NONE);
        wr_v_r    <= 2'(N_id_i % 10'd4);
      end else if (wr_en_s) begin
        wr_cnt_r <= wr_cnt_r + 8'd1;
      end
      if (done_s) wr_bank_r <= ~wr_bank_r;
      if (start_s && (wr_state_r == WR_FILL)) err_abort_o <= 1'b1;
    end
  end

  // Symbol RAM, two banks of FFT_LEN bins
  always_ff @(posedge clk_i) begin
    if (wr_en_s) mem_r[{wr_bank_r, wr_bin_s}] <= s_axis_in_tdata;
  end

  // Read FSM next state and per-k routing
  always_comb begin
    rd_state_nxt_s = rd_state_r;
    rd_go_s        = done_s && (wr_kind_r != KIND_NONE);
    sss_sel_s      = 1'b0;
    sss_last_s     = 1'b0;
    pbch_sel_s     = 1'b0;
    pbch_last_s    = 1'b0;
    if (rd_go_s) begin
      rd_state_nxt_s = RD_READ;
    end else begin
      case (rd_state_r)
        RD_READ: rd_state_nxt_s = (rd_k_r == K_LAST) ? RD_IDLE : RD_READ;
        RD_IDLE: rd_state_nxt_s = RD_IDLE;
        default: rd_state_nxt_s = RD_IDLE;
      endcase
    end
    if (rd_state_r == RD_READ) begin
      case (rd_kind_r)
        KIND_SSS: begin
          sss_sel_s   = (rd_k_r >= SSS_FIRST) && (rd_k_r <= SSS_LAST);
          sss_last_s  = (rd_k_r == SSS_LAST);
          pbch_sel_s  = (rd_k_r <= PBCH_LO_LAST) || (rd_k_r >= PBCH_HI_FIRST);
          pbch_last_s = (rd_k_r == K_LAST);
        end
        KIND_PBCH: begin
          pbch_sel_s  = 1'b1;
          pbch_last_s = (rd_k_r == K_LAST);
        end
        default: begin
          sss_sel_s  = 1'b0;
          pbch_sel_s = 1'b0;
        end
      endcase
    end else begin
      sss_sel_s  = 1'b0;
      pbch_sel_s = 1'b0;
    end
  end

  // Read FSM state and subcarrier counter; a new handoff restarts readout
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_state_r    <= RD_IDLE;
      rd_k_r        <= 8'd0;
      rd_bank_r     <= 1'b0;
      rd_kind_r     <= KIND_NONE;
      rd_v_r        <= 2'd0;
      err_overrun_o <= 1'b0;
    end else begin
      rd_state_r <= rd_state_nxt_s;
      if (rd_go_s) begin
        rd_k_r    <= 8'd0;
        rd_bank_r <= wr_bank_r;
        rd_kind_r <= wr_kind_r;
        rd_v_r    <= wr_v_r;
      end else if (rd_state_r == RD_READ) begin
        rd_k_r <= rd_k_r + 8'd1;
      end
      if (rd_go_s && (rd_state_r == RD_READ)) err_overrun_o <= 1'b1;
    end
  end

  // Output registers double as the RAM read register; tdata holds when idle
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      m_axis_sss_tdata   <= '0;
      m_axis_sss_tvalid  <= 1'b0;
      m_axis_sss_tlast   <= 1'b0;
      m_axis_pbch_tdata  <= '0;
      m_axis_pbch_tvalid <= 1'b0;
      m_axis_pbch_tuser  <= 1'b0;
      m_axis_pbch_tlast  <= 1'b0;
    end else begin
      m_axis_sss_tvalid  <= sss_sel_s;
      m_axis_sss_tlast   <= sss_sel_s && sss_last_s;
      m_axis_pbch_tvalid <= pbch_sel_s;
      m_axis_pbch_tlast  <= pbch_sel_s && pbch_last_s;
      m_axis_pbch_tuser  <= pbch_sel_s && dmrs_s;
      if (sss_sel_s) m_axis_sss_tdata <= mem_r[{rd_bank_r, rd_addr_s}];
      if (pbch_sel_s) m_axis_pbch_tdata <= mem_r[{rd_bank_r, rd_addr_s}];
    end
  end

endmodule

// File: tb/tb_ssb_re_demapper.sv
// Directed self-checking bench for ssb_re_demapper: each task drives one scenario
// and compares captured output REs against hand-derived subcarrier/bin mappings.
module tb_ssb_re_demapper;

  localparam int DW = 42;

  logic          clk_i = 1'b0;
  logic          reset_ni = 1'b0;
  logic [DW-1:0] s_axis_in_tdata = '0;
  logic          s_axis_in_tvalid = 1'b0;
  logic          symbol_start_i = 1'b0;
  logic          PBCH_valid_i = 1'b0;
  logic          SSS_valid_i = 1'b0;
  logic [9:0]    N_id_i = 10'd0;
  logic [DW-1:0] m_axis_sss_tdata;
  logic          m_axis_sss_tvalid;
  logic          m_axis_sss_tlast;
  logic [DW-1:0] m_axis_pbch_tdata;
  logic          m_axis_pbch_tvalid;
  logic          m_axis_pbch_tuser;
  logic          m_axis_pbch_tlast;
  logic          err_abort_o;
  logic          err_overrun_o;

  ssb_re_demapper #(.DW(DW)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .s_axis_in_tdata(s_axis_in_tdata), .s_axis_in_tvalid(s_axis_in_tvalid),
    .symbol_start_i(symbol_start_i), .PBCH_valid_i(PBCH_valid_i),
    .SSS_valid_i(SSS_valid_i), .N_id_i(N_id_i),
    .m_axis_sss_tdata(m_axis_sss_tdata), .m_axis_sss_tvalid(m_axis_sss_tvalid),
    .m_axis_sss_tlast(m_axis_sss_tlast),
    .m_axis_pbch_tdata(m_axis_pbch_tdata), .m_axis_pbch_tvalid(m_axis_pbch_tvalid),
    .m_axis_pbch_tuser(m_axis_pbch_tuser), .m_axis_pbch_tlast(m_axis_pbch_tlast),
    .err_abort_o(err_abort_o), .err_overrun_o(err_overrun_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [DW-1:0] d;
    logic          u;
    logic          l;
    int            c;
  } re_t;

  re_t sss_q[$];
  re_t pbch_q[$];
  int  both_cnt = 0;
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Capture every emitted RE with the cycle it was visible in
  always @(negedge clk_i) begin
    if (reset_ni) begin
      if (m_axis_sss_tvalid && m_axis_pbch_tvalid) both_cnt++;
      if (m_axis_sss_tvalid)
        sss_q.push_back('{m_axis_sss_tdata, 1'b0, m_axis_sss_tlast, cyc});
      if (m_axis_pbch_tvalid)
        pbch_q.push_back('{m_axis_pbch_tdata, m_axis_pbch_tuser, m_axis_pbch_tlast, cyc});
    end
  end

  // PBCH RE index i -> subcarrier k (SSS symbols skip k=48..191)
  function automatic int pb_k(input bit sss, input int i);
    return sss ? ((i < 48) ? i : i + 144) : i;
  endfunction

  // Drive nbins bins (data = base*256 + bin); c_done = cycle of the last bin
  task automatic send_sym(input logic pb, input logic ss, input logic [9:0] nid,
                          input int base, input int nbins, input bit gaps,
                          output int c_done);
    for (int b = 0; b < nbins; b++) begin
      if (gaps) begin
        int n;
        n = $urandom_range(0, 3);
        repeat (n) begin
          s_axis_in_tvalid = 1'b0;
          symbol_start_i   = 1'b0;
          @(posedge clk_i); #1;
        end
      end
      s_axis_in_tvalid = 1'b1;
      s_axis_in_tdata  = DW'(base * 256 + b);
      symbol_start_i   = (b == 0);
      PBCH_valid_i     = pb;
      SSS_valid_i      = ss;
      N_id_i           = nid;
      c_done           = cyc;
      @(posedge clk_i); #1;
    end
    s_axis_in_tvalid = 1'b0;
    symbol_start_i   = 1'b0;
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({m_axis_sss_tvalid, m_axis_sss_tlast, m_axis_pbch_tvalid, m_axis_pbch_tuser,
         m_axis_pbch_tlast, err_abort_o, err_overrun_o} !== 7'd0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 0000000", {m_axis_sss_tvalid, m_axis_sss_tlast,
               m_axis_pbch_tvalid, m_axis_pbch_tuser, m_axis_pbch_tlast, err_abort_o, err_overrun_o});
    end
    checks++;
    if (m_axis_sss_tdata !== '0) begin
      errors++; $display("FAIL reset_sss_data got %0h exp 0", m_axis_sss_tdata);
    end
    checks++;
    if (m_axis_pbch_tdata !== '0) begin
      errors++; $display("FAIL reset_pbch_data got %0h exp 0", m_axis_pbch_tdata);
    end
    reset_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  // Scenario 1 (gaps=0) and scenario 4 (gaps=1): PBCH, N_id=0, data = bin index
  task automatic test_pbch(input bit gaps, input string tag);
    int c, n;
    logic [DW-1:0] e;
    logic eu, el;
    sss_q.delete(); pbch_q.delete(); both_cnt = 0;
    send_sym(1'b1, 1'b0, 10'd0, 0, 256, gaps, c);
    repeat (260) @(posedge clk_i);
    #1;
    checks++;
    if (pbch_q.size() !== 240) begin
      errors++; $display("FAIL %s pbch_count got %0d exp 240", tag, pbch_q.size());
    end
    checks++;
    if (sss_q.size() !== 0) begin
      errors++; $display("FAIL %s sss_count got %0d exp 0", tag, sss_q.size());
    end
    n = (pbch_q.size() < 240) ? pbch_q.size() : 240;
    for (int i = 0; i < n; i++) begin
      e  = DW'((i + 136) % 256);
      eu = ((i % 4) == 0);
      el = (i == 239);
      checks++;
      if ({pbch_q[i].d, pbch_q[i].u, pbch_q[i].l} !== {e, eu, el}) begin
        errors++;
        $display("FAIL %s pbch_re k=%0d got d=%0d u=%b l=%b exp d=%0d u=%b l=%b", tag, i,
                 pbch_q[i].d, pbch_q[i].u, pbch_q[i].l, e, eu, el);
      end
      checks++;
      if (pbch_q[i].c !== c + 2 + i) begin
        errors++;
        $display("FAIL %s pbch_cycle k=%0d got %0d exp %0d", tag, i, pbch_q[i].c, c + 2 + i);
      end
    end
  endtask

  // Scenario 2: SSS symbol, N_id=5 (v=1)
  task automatic test_sss();
    int c, n, k;
    logic [DW-1:0] e;
    logic eu, el;
    sss_q.delete(); pbch_q.delete(); both_cnt = 0;
    send_sym(1'b0, 1'b1, 10'd5, 0, 256, 1'b0, c);
    repeat (260) @(posedge clk_i);
    #1;
    checks++;
    if (sss_q.size() !== 127) begin
      errors++; $display("FAIL sss sss_count got %0d exp 127", sss_q.size());
    end
    checks++;
    if (pbch_q.size() !== 96) begin
      errors++; $display("FAIL sss pbch_count got %0d exp 96", pbch_q.size());
    end
    checks++;
    if (both_cnt !== 0) begin
      errors++; $display("FAIL sss both_valid got %0d exp 0", both_cnt);
    end
    n = (sss_q.size() < 127) ? sss_q.size() : 127;
    for (int i = 0; i < n; i++) begin
      e  = DW'((192 + i) % 256);
      el = (i == 126);
      checks++;
      if ({sss_q[i].d, sss_q[i].l, sss_q[i].c} !== {e, el, c + 58 + i}) begin
        errors++;
        $display("FAIL sss sss_re i=%0d got d=%0d l=%b c=%0d exp d=%0d l=%b c=%0d", i,
                 sss_q[i].d, sss_q[i].l, sss_q[i].c, e, el, c + 58 + i);
      end
    end
    n = (pbch_q.size() < 96) ? pbch_q.size() : 96;
    for (int i = 0; i < n; i++) begin
      k  = pb_k(1'b1, i);
      e  = DW'((k + 136) % 256);
      eu = ((k % 4) == 1);
      el = (i == 95);
      checks++;
      if ({pbch_q[i].d, pbch_q[i].u, pbch_q[i].l, pbch_q[i].c} !== {e, eu, el, c + 2 + k}) begin
        errors++;
        $display("FAIL sss pbch_re k=%0d got d=%0d u=%b l=%b c=%0d exp d=%0d u=%b l=%b c=%0d",
                 k, pbch_q[i].d, pbch_q[i].u, pbch_q[i].l, pbch_q[i].c, e, eu, el, c + 2 + k);
      end
    end
  endtask

  // Scenario 3: PBCH, SSS, PBCH with 18 idle cycles between symbols
  task automatic test_back_to_back();
    int cs[3];
    int nid[3];
    int j, k, cnt, n;
    logic [DW-1:0] e;
    logic eu, el;
    nid[0] = 0; nid[1] = 6; nid[2] = 3;
    sss_q.delete(); pbch_q.delete(); both_cnt = 0;
    for (int s = 0; s < 3; s++) begin
      send_sym(s != 1, s == 1, 10'(nid[s]), s + 1, 256, 1'b0, cs[s]);
      repeat (18) @(posedge clk_i);
      #1;
    end
    repeat (260) @(posedge clk_i);
    #1;
    checks++;
    if (pbch_q.size() !== 576) begin
      errors++; $display("FAIL b2b pbch_count got %0d exp 576", pbch_q.size());
    end
    checks++;
    if (sss_q.size() !== 127) begin
      errors++; $display("FAIL b2b sss_count got %0d exp 127", sss_q.size());
    end
    checks++;
    if ({err_abort_o, err_overrun_o} !== 2'b00) begin
      errors++; $display("FAIL b2b err_flags got %b exp 00", {err_abort_o, err_overrun_o});
    end
    j = 0;
    for (int s = 0; s < 3; s++) begin
      cnt = (s == 1) ? 96 : 240;
      for (int i = 0; i < cnt; i++) begin
        k  = pb_k(s == 1, i);
        e  = DW'((s + 1) * 256 + (k + 136) % 256);
        eu = ((k % 4) == nid[s] % 4);
        el = (i == cnt - 1);
        if (j < pbch_q.size()) begin
          checks++;
          if ({pbch_q[j].d, pbch_q[j].u, pbch_q[j].l, pbch_q[j].c} !==
              {e, eu, el, cs[s] + 2 + k}) begin
            errors++;
            $display("FAIL b2b pbch_re sym=%0d k=%0d got d=%0h u=%b l=%b c=%0d exp d=%0h u=%b l=%b c=%0d",
                     s, k, pbch_q[j].d, pbch_q[j].u, pbch_q[j].l, pbch_q[j].c, e, eu, el, cs[s] + 2 + k);
          end
        end
        j++;
      end
    end
    n = (sss_q.size() < 127) ? sss_q.size() : 127;
    for (int i = 0; i < n; i++) begin
      e = DW'(512 + (192 + i) % 256);
      checks++;
      if ({sss_q[i].d, sss_q[i].l} !== {e, i == 126}) begin
        errors++;
        $display("FAIL b2b sss_re i=%0d got d=%0h l=%b exp d=%0h", i, sss_q[i].d, sss_q[i].l, e);
      end
    end
  endtask

  // Scenario 5: restart at bin 100, then a full PBCH symbol
  task automatic test_abort();
    int c0, c, n;
    logic [DW-1:0] e;
    sss_q.delete(); pbch_q.delete(); both_cnt = 0;
    send_sym(1'b1, 1'b0, 10'd0, 6, 100, 1'b0, c0);
    send_sym(1'b1, 1'b0, 10'd0, 7, 256, 1'b0, c);
    repeat (260) @(posedge clk_i);
    #1;
    checks++;
    if (err_abort_o !== 1'b1) begin
      errors++; $display("FAIL abort err_abort got %b exp 1", err_abort_o);
    end
    checks++;
    if (err_overrun_o !== 1'b0) begin
      errors++; $display("FAIL abort err_overrun got %b exp 0", err_overrun_o);
    end
    checks++;
    if (pbch_q.size() !== 240) begin
      errors++; $display("FAIL abort pbch_count got %0d exp 240", pbch_q.size());
    end
    n = (pbch_q.size() < 240) ? pbch_q.size() : 240;
    for (int i = 0; i < n; i++) begin
      e = DW'(7 * 256 + (i + 136) % 256);
      checks++;
      if ({pbch_q[i].d, pbch_q[i].c} !== {e, c + 2 + i}) begin
        errors++;
        $display("FAIL abort pbch_re k=%0d got d=%0h c=%0d exp d=%0h c=%0d", i,
                 pbch_q[i].d, pbch_q[i].c, e, c + 2 + i);
      end
    end
  endtask

  // Scenario 6: reset at k=50 of a readout, then a clean PBCH symbol
  task automatic test_reset_mid();
    int c, n;
    logic [DW-1:0] e;
    sss_q.delete(); pbch_q.delete(); both_cnt = 0;
    send_sym(1'b1, 1'b0, 10'd0, 9, 256, 1'b0, c);
    repeat (51) @(posedge clk_i);
    #1;
    e = DW'(9 * 256 + 186);
    checks++;
    if ({m_axis_pbch_tvalid, m_axis_pbch_tdata} !== {1'b1, e}) begin
      errors++;
      $display("FAIL rstmid pre_reset got v=%b d=%0h exp v=1 d=%0h", m_axis_pbch_tvalid,
               m_axis_pbch_tdata, e);
    end
    reset_ni = 1'b0;
    #1;
    checks++;
    if ({m_axis_sss_tvalid, m_axis_sss_tlast, m_axis_pbch_tvalid, m_axis_pbch_tuser,
         m_axis_pbch_tlast, err_abort_o, err_overrun_o} !== 7'd0) begin
      errors++;
      $display("FAIL rstmid ctrl got %b exp 0000000", {m_axis_sss_tvalid, m_axis_sss_tlast,
               m_axis_pbch_tvalid, m_axis_pbch_tuser, m_axis_pbch_tlast, err_abort_o, err_overrun_o});
    end
    checks++;
    if ({m_axis_sss_tdata, m_axis_pbch_tdata} !== {2 * DW{1'b0}}) begin
      errors++;
      $display("FAIL rstmid data got sss=%0h pbch=%0h exp 0", m_axis_sss_tdata, m_axis_pbch_tdata);
    end
    repeat (3) @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
    @(posedge clk_i); #1;
    sss_q.delete(); pbch_q.delete();
    send_sym(1'b1, 1'b0, 10'd0, 10, 256, 1'b0, c);
    repeat (260) @(posedge clk_i);
    #1;
    checks++;
    if (pbch_q.size() !== 240) begin
      errors++; $display("FAIL rstmid pbch_count got %0d exp 240", pbch_q.size());
    end
    checks++;
    if ({err_abort_o, err_overrun_o} !== 2'b00) begin
      errors++; $display("FAIL rstmid err_flags got %b exp 00", {err_abort_o, err_overrun_o});
    end
    n = (pbch_q.size() < 240) ? pbch_q.size() : 240;
    for (int i = 0; i < n; i++) begin
      e = DW'(10 * 256 + (i + 136) % 256);
      checks++;
      if ({pbch_q[i].d, pbch_q[i].u, pbch_q[i].l, pbch_q[i].c} !==
          {e, (i % 4) == 0, i == 239, c + 2 + i}) begin
        errors++;
        $display("FAIL rstmid pbch_re k=%0d got d=%0h u=%b l=%b c=%0d exp d=%0h c=%0d", i,
                 pbch_q[i].d, pbch_q[i].u, pbch_q[i].l, pbch_q[i].c, e, c + 2 + i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pbch(1'b0, "pbch");
    test_sss();
    test_back_to_back();
    test_pbch(1'b1, "gaps");
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
